// File: rtl/ps2_scancode_rx_fifo.sv
// PS/2 device-to-host receiver running entirely in the system clock domain.
// Conditions the raw pins, deframes 11-bit frames (start, 8 data LSB-first,
// odd parity, stop), folds E0/F0 prefixes into a tagged event and buffers
// events in a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst             system clock, async active-high reset
//   ps2_clk, ps2_data    raw asynchronous PS/2 pins
//   rd_valid/rd_ready    FIFO read handshake; rd_data = {brk, ext, code}
//   level                FIFO occupancy
//   parity_err, frame_err, overflow   sticky error flags, cleared by err_clr
module ps2_scancode_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ps2_clk,
  input  logic                              ps2_data,
  output logic                              rd_valid,
  input  logic                              rd_ready,
  output logic [9:0]                        rd_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              parity_err,
  output logic                              frame_err,
  output logic                              overflow,
  input  logic                              err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Input conditioning
  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      filt     <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
      fall    <= 1'b0;
      // filt_cnt counts consecutive samples disagreeing with filt; the
      // FILTER_LEN-th one flips filt and, for a 1->0 flip, raises fall for
      // exactly the cycle in which filt first reads 0.
      if (clk_s2 == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt     <= clk_s2;
        filt_cnt <= '0;
        fall     <= filt;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  // Frame FSM
  state_t        state, state_n;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          brk_pend, ext_pend;
  logic          timeout, push, set_fe, set_pe, clr_pend, set_ext, set_brk;

  always_comb begin
    state_n  = state;
    push     = 1'b0;
    set_fe   = 1'b0;
    set_pe   = 1'b0;
    clr_pend = 1'b0;
    set_ext  = 1'b0;
    set_brk  = 1'b0;
    timeout  = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    if (timeout) begin
      state_n  = IDLE;
      set_fe   = 1'b1;
      clr_pend = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (data_s2) begin
            set_fe   = 1'b1;
            clr_pend = 1'b1;
          end else begin
            state_n = DATA;
          end
        end
        DATA:   if (bit_cnt == 3'd7) state_n = PARITY;
        PARITY: state_n = STOP;
        STOP: begin
          state_n = IDLE;
          if (!data_s2) set_fe = 1'b1;
          if (!(^{shift, par_bit})) set_pe = 1'b1;
          if (data_s2 && (^{shift, par_bit})) begin
            if (shift == 8'hE0) begin
              set_ext = 1'b1;
            end else if (shift == 8'hF0) begin
              set_brk = 1'b1;
            end else begin
              push     = 1'b1;
              clr_pend = 1'b1;
            end
          end else begin
            clr_pend = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      par_bit  <= 1'b0;
      to_cnt   <= '0;
      brk_pend <= 1'b0;
      ext_pend <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE || fall) to_cnt <= '0;
      else                       to_cnt <= to_cnt + TW'(1);
      if (fall) begin
        case (state)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            shift   <= {data_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par_bit <= data_s2;
          default: ;
        endcase
      end
      if (clr_pend) begin
        brk_pend <= 1'b0;
        ext_pend <= 1'b0;
      end else begin
        if (set_brk) brk_pend <= 1'b1;
        if (set_ext) ext_pend <= 1'b1;
      end
    end
  end

  // Event FIFO
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [LW-1:0] count, remain;
  logic [9:0]    wdata;
  logic          pop, full, wr_en;

  assign wdata    = {brk_pend, ext_pend, shift};
  assign rd_valid = (count != '0);
  assign level    = count;
  assign pop      = rd_valid && rd_ready;
  assign full     = (count == LW'(FIFO_DEPTH));
  assign wr_en    = push && (!full || pop);
  assign rd_ptr_n = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign remain   = pop ? count - LW'(1) : count;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_data    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_n;
      if (wr_en && !pop)      count <= count + LW'(1);
      else if (!wr_en && pop) count <= count - LW'(1);
      // rd_data is preloaded with the next head: the incoming word when the
      // queue would otherwise be empty, else the stored entry at rd_ptr_n.
      if (remain == '0) begin
        if (wr_en) rd_data <= wdata;
      end else begin
        rd_data <= mem[rd_ptr_n];
      end
      parity_err <= (parity_err & ~err_clr) | set_pe;
      frame_err  <= (frame_err & ~err_clr) | set_fe;
      overflow   <= (overflow & ~err_clr) | (push && full && !pop);
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx_fifo.sv
// Directed bench for ps2_scancode_rx_fifo: a table of single frames with
// expected outputs, plus hand-written sequences for latency, timeout,
// overflow, reset mid-frame and clock glitch filtering.
module tb_ps2_scancode_rx_fifo;

  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst, ps2_clk, ps2_data, rd_ready, err_clr;
  logic       rd_valid, parity_err, frame_err, overflow;
  logic [9:0] rd_data;
  logic [3:0] level;

  int checks = 0;
  int errors = 0;

  ps2_scancode_rx_fifo #(
    .FIFO_DEPTH(8),
    .FILTER_LEN(4),
    .TIMEOUT_CYCLES(300)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .level(level), .parity_err(parity_err), .frame_err(frame_err),
    .overflow(overflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    bit         exp_valid;
    logic [9:0] exp_data;
    int         exp_level;
    bit         exp_pe;
    bit         exp_fe;
    bit         pop_after;
    bit         clr_after;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // start, data LSB-first, parity (odd unless bad_par)
  task automatic send_head(input logic [7:0] code, input bit bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit((~^code) ^ bad_par);
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
    send_head(code, bad_par);
    ps2_bit(~bad_stop);
    repeat (10) @(negedge clk);
  endtask

  task automatic do_pop();
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [9:0] drain_exp [8];

    vecs[0]  = '{8'h1C, 0, 0, 1, 10'h01C, 1, 0, 0, 1, 0};
    vecs[1]  = '{8'hE0, 0, 0, 0, 10'h000, 0, 0, 0, 0, 0};
    vecs[2]  = '{8'hF0, 0, 0, 0, 10'h000, 0, 0, 0, 0, 0};
    vecs[3]  = '{8'h75, 0, 0, 1, 10'h375, 1, 0, 0, 1, 0};
    vecs[4]  = '{8'h75, 0, 0, 1, 10'h075, 1, 0, 0, 1, 0};
    vecs[5]  = '{8'hE0, 0, 0, 0, 10'h000, 0, 0, 0, 0, 0};
    vecs[6]  = '{8'h6B, 0, 0, 1, 10'h16B, 1, 0, 0, 1, 0};
    vecs[7]  = '{8'h1C, 1, 0, 0, 10'h000, 0, 1, 0, 0, 1};
    vecs[8]  = '{8'hF0, 0, 0, 0, 10'h000, 0, 0, 0, 0, 0};
    vecs[9]  = '{8'h5A, 0, 1, 0, 10'h000, 0, 0, 1, 0, 1};
    vecs[10] = '{8'h5A, 0, 0, 1, 10'h05A, 1, 0, 0, 1, 0};
    vecs[11] = '{8'hE0, 0, 0, 0, 10'h000, 0, 0, 0, 0, 0};
    vecs[12] = '{8'h29, 1, 1, 0, 10'h000, 0, 1, 1, 0, 1};
    vecs[13] = '{8'h29, 0, 0, 1, 10'h029, 1, 0, 0, 1, 0};

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset rd_valid", 32'(rd_valid), 0);
    chk("reset rd_data", 32'(rd_data), 0);
    chk("reset level", 32'(level), 0);
    chk("reset flags", {29'd0, parity_err, frame_err, overflow}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 14; v++) begin
      send_frame(vecs[v].code, vecs[v].bad_par, vecs[v].bad_stop);
      chk($sformatf("vec%0d rd_valid", v), 32'(rd_valid), 32'(vecs[v].exp_valid));
      if (vecs[v].exp_valid) chk($sformatf("vec%0d rd_data", v), 32'(rd_data), 32'(vecs[v].exp_data));
      chk($sformatf("vec%0d level", v), 32'(level), 32'(vecs[v].exp_level));
      chk($sformatf("vec%0d parity_err", v), 32'(parity_err), 32'(vecs[v].exp_pe));
      chk($sformatf("vec%0d frame_err", v), 32'(frame_err), 32'(vecs[v].exp_fe));
      if (vecs[v].pop_after) begin
        do_pop();
        chk($sformatf("vec%0d post-pop valid", v), 32'(rd_valid), 0);
        chk($sformatf("vec%0d post-pop level", v), 32'(level), 0);
      end
      if (vecs[v].clr_after) begin
        do_clr();
        chk($sformatf("vec%0d cleared flags", v), {30'd0, parity_err, frame_err}, 0);
      end
    end

    // Push latency: 2 sync + 4 filter samples put the fall event in the cycle
    // after the 6th edge; the entry appears after the 7th.
    send_head(8'h1C, 0);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("latency not yet valid", 32'(rd_valid), 0);
    @(posedge clk);
    #1 chk("latency valid", 32'(rd_valid), 1);
    chk("latency data", 32'(rd_data), 32'h01C);
    chk("latency level", 32'(level), 1);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
    do_pop();

    // Timeout after a partial frame
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    repeat (310) @(negedge clk);
    chk("timeout frame_err", 32'(frame_err), 1);
    chk("timeout level", 32'(level), 0);
    do_clr();
    send_frame(8'h2A, 0, 0);
    chk("after timeout data", 32'(rd_data), 32'h02A);
    chk("after timeout level", 32'(level), 1);
    chk("after timeout errs", {30'd0, parity_err, frame_err}, 0);
    do_pop();

    // Overflow: 9 frames into depth 8
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0);
    chk("full level", 32'(level), 8);
    chk("overflow set", 32'(overflow), 1);
    chk("full head", 32'(rd_data), 32'h001);
    do_clr();
    chk("overflow cleared", 32'(overflow), 0);
    // Push 0x0A while full, popping in the push cycle
    send_head(8'h0A, 0);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (6) @(posedge clk);
    #1 rd_ready = 1'b1;
    @(posedge clk);
    #1 rd_ready = 1'b0;
    chk("push+pop full level", 32'(level), 8);
    chk("push+pop no overflow", 32'(overflow), 0);
    chk("push+pop head", 32'(rd_data), 32'h002);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
    drain_exp = '{10'h002, 10'h003, 10'h004, 10'h005, 10'h006, 10'h007, 10'h008, 10'h00A};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), 32'(rd_data), 32'(drain_exp[i]));
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
    end
    @(negedge clk);
    chk("drained level", 32'(level), 0);

    // Reset in the middle of data bits
    send_frame(8'h11, 0, 0);
    chk("pre-reset level", 32'(level), 1);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid-reset level", 32'(level), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h33, 0, 0);
    chk("post-reset level", 32'(level), 1);
    chk("post-reset data", 32'(rd_data), 32'h033);
    chk("post-reset flags", {29'd0, parity_err, frame_err, overflow}, 0);
    do_pop();

    // 3-cycle low glitch is filtered out; a 4-cycle low becomes a fall event
    // which, with data high, is a bad start bit.
    ps2_data = 1'b1;
    ps2_clk  = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch frame_err", 32'(frame_err), 0);
    chk("glitch level", 32'(level), 0);
    ps2_clk = 1'b0;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    chk("4-cycle low frame_err", 32'(frame_err), 1);
    do_clr();
    send_frame(8'h44, 0, 0);
    chk("after glitch data", 32'(rd_data), 32'h044);
    chk("after glitch level", 32'(level), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx_fifo.md
Name: ps2_scancode_rx_fifo

Overview:
Parametrised successor to the current keyboard front-end. It receives PS/2 device-to-host frames in the system clock domain instead of clocking logic from the PS/2 clock. It checks start, parity and stop bits, folds E0 (extended) and F0 (break) prefixes into a tagged key event, and buffers events in a FIFO with a valid/ready read port. It sits between the PS/2 pins and the instruction decoder/controller. The decoder pops one event per instruction.

Parameters:
FIFO_DEPTH, 8, number of buffered key events; power of two, minimum 2.
FILTER_LEN, 4, consecutive equal samples required before the filtered PS/2 clock changes level.
TIMEOUT_CYCLES, 50000, clk cycles without a PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  reset, asynchronous and active-high; clears all state.
ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
ps2_data  in  1  raw PS/2 data pin, asynchronous.
rd_valid  out  1  FIFO non-empty; rd_data is valid.
rd_ready  in  1  consumer accepts the head entry.
rd_data  out  10  {brk, ext, code[7:0]} of the head entry.
level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
parity_err  out  1  sticky flag: a frame failed odd parity.
frame_err  out  1  sticky flag: bad start bit, bad stop bit, or timeout.
overflow  out  1  sticky flag: an event was dropped because the FIFO was full.
err_clr  in  1  one-cycle pulse that clears all three sticky flags.

Behaviour:
- Reset values:
  - rd_valid=0, rd_data=0, level=0, all sticky flags 0.
  - FSM in IDLE; brk/ext pending flags 0.
  - Synchronisers and filtered clock preset to 1 (bus idle high).
- Input conditioning:
  - Two-flop synchroniser on both pins.
  - The filtered clock takes a new level only after FILTER_LEN consecutive synchronised samples at that level.
  - A fall event is a 1->0 transition of the filtered clock. It lasts one cycle, and synchronised ps2_data is sampled in that cycle.
- Frame FSM, all transitions on fall events only:
  - IDLE -> DATA if sampled bit=0. If sampled bit=1, stay in IDLE and set frame_err.
  - DATA: shift 8 bits LSB-first, then -> PARITY.
  - PARITY: capture the bit, then -> STOP.
  - STOP: frame_ok if stop=1 AND (popcount(data)+parity) is odd.
  - Stop=0 sets frame_err. Parity failure sets parity_err. If both fail, set both.
  - The FSM always returns to IDLE after STOP.
- Timeout: in DATA, PARITY or STOP, a counter counts cycles since the last fall event and resets on each fall. When it reaches TIMEOUT_CYCLES:
  - return to IDLE and discard the partial byte;
  - set frame_err;
  - clear the pending prefix flags.
- Prefix folding on frame_ok:
  - byte E0: set ext_pend; no push.
  - byte F0: set brk_pend; no push.
  - any other byte: push {brk_pend, ext_pend, byte}, then clear both pending flags.
  - Any frame error or parity error also clears both pending flags.
- FIFO:
  - First-word-fall-through; rd_data is registered and shows the head whenever rd_valid=1.
  - Pop occurs when rd_valid && rd_ready.
  - Push while full with no pop: drop the event, set overflow, level unchanged.
  - Push and pop in the same cycle while full: both occur, no drop.
  - Pop request while empty: ignored.
  - Push and pop together: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency:
  - The pushed entry is visible on rd_valid/rd_data in the cycle after the stop-bit fall event.
  - After a pop, the next entry is presented the following cycle.
- Sticky flags: err_clr clears them. If a new error occurs in the same cycle as err_clr, the flag reads 1 afterwards.
- Reset mid-frame: the partial frame is discarded, and no push occurs after reset deasserts until a complete new frame arrives.
- Write-side back-pressure is not possible. The PS/2 device cannot be stalled; dropping on full is the only policy.

Test Plan:
- Single frame 0x1C: start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1 -> one cycle after the stop fall event rd_valid=1, rd_data=0x01C, level=1; rd_ready pulse -> rd_valid=0, level=0.
- Sequence E0, F0, 75 (each a valid frame) -> exactly one entry, rd_data=0x375; then a frame 75 -> rd_data=0x075, showing the flags cleared.
- Frame 0x1C with parity bit 1 -> no push, parity_err=1, level=0. Then pulse err_clr -> parity_err=0.
- Send start plus 4 data bits, idle for TIMEOUT_CYCLES+10 cycles -> frame_err=1, FSM in IDLE. Then a valid frame 0x2A -> rd_data=0x02A.
- FIFO_DEPTH+1 frames 0x01..0x09 (depth 8) with rd_ready=0 -> level=8, overflow=1. Drain reads 0x001..0x008 in order; 0x009 is absent. Also exercise a simultaneous push and pop while full -> no drop.
- Assert rst midway through the data bits of a frame, release, then send a valid frame 0x33 -> only 0x033 in the FIFO, all flags 0. A 1-cycle glitch on ps2_clk (shorter than FILTER_LEN) -> no fall event, FSM state unchanged.
